// File: rtl/predictor_access_ctrl.sv
// Shares the branch predictor's single address port between in-order lookups
// and FIFO-buffered updates, with a starvation override for pending updates.
module predictor_access_ctrl #(
  parameter int ADDR_W       = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lk_valid_i,
  input  logic [ADDR_W-1:0]             lk_addr_i,
  output logic                          lk_ready_o,
  output logic                          lk_resp_valid_o,
  output logic                          lk_resp_taken_o,
  input  logic                          up_valid_i,
  input  logic [ADDR_W-1:0]             up_addr_i,
  input  logic                          up_result_i,
  output logic                          up_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   up_count_o,
  output logic                          pred_cs_o,
  output logic [ADDR_W-1:0]             pred_addr_o,
  output logic                          pred_result_o,
  input  logic                          pred_prediction_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {GRANT_IDLE, GRANT_LOOKUP, GRANT_UPDATE} grant_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              result;
  } upd_t;

  upd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ST_W-1:0]  starve_q, starve_d;
  logic             resp_valid_q, resp_valid_d;

  grant_e grant;
  logic   fifo_empty, fifo_full, force_upd, push, pop;
  upd_t   head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign force_upd  = fifo_full || (starve_q >= ST_W'(STARVE_LIMIT));
  assign head       = mem_q[rd_ptr_q];

  // Reset blocks every grant so the predictor sees no strobe while rst is high.
  always_comb begin
    grant = GRANT_IDLE;
    if (!rst) begin
      if (force_upd && !fifo_empty) grant = GRANT_UPDATE;
      else if (lk_valid_i)          grant = GRANT_LOOKUP;
      else if (!fifo_empty)         grant = GRANT_UPDATE;
    end
  end

  always_comb begin
    lk_ready_o    = 1'b0;
    pred_cs_o     = 1'b0;
    pred_addr_o   = '0;
    pred_result_o = 1'b0;
    case (grant)
      GRANT_LOOKUP: begin
        lk_ready_o  = 1'b1;
        pred_addr_o = lk_addr_i;
      end
      GRANT_UPDATE: begin
        pred_cs_o     = 1'b1;
        pred_addr_o   = head.addr;
        pred_result_o = head.result;
      end
      default: ;
    endcase
  end

  assign up_ready_o      = !rst && !fifo_full;
  assign up_count_o      = count_q;
  assign push            = up_valid_i && up_ready_o;
  assign pop             = (grant == GRANT_UPDATE);
  assign lk_resp_valid_o = resp_valid_q;
  // The predictor registers its output itself, so the response is a pass-through.
  assign lk_resp_taken_o = resp_valid_q & pred_prediction_i;

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    resp_valid_d = (grant == GRANT_LOOKUP);
    starve_d     = starve_q;
    if (pop || fifo_empty)
      starve_d = '0;
    else if (grant == GRANT_LOOKUP && starve_q < ST_W'(STARVE_LIMIT))
      starve_d = starve_q + ST_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // NOTE: storage is not reset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: up_addr_i, result: up_result_i};
  end

endmodule

// File: tb/tb_predictor_access_ctrl.sv
// Bench for predictor_access_ctrl: a 2-bit saturating predictor model, update and
// lookup scoreboards, a grant vector table, and directed multi-cycle sequences.
module tb_predictor_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       lk_valid, lk_addr;
  logic       lk_ready, lk_resp_valid, lk_resp_taken;
  logic       up_valid, up_addr, up_result;
  logic       up_ready;
  logic [2:0] up_count;
  logic       pred_cs, pred_addr, pred_result;
  logic       pred_prediction = 1'b0;

  int total = 0;
  int bad   = 0;

  predictor_access_ctrl #(.ADDR_W(1), .FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .lk_valid_i(lk_valid), .lk_addr_i(lk_addr), .lk_ready_o(lk_ready),
    .lk_resp_valid_o(lk_resp_valid), .lk_resp_taken_o(lk_resp_taken),
    .up_valid_i(up_valid), .up_addr_i(up_addr), .up_result_i(up_result),
    .up_ready_o(up_ready), .up_count_o(up_count),
    .pred_cs_o(pred_cs), .pred_addr_o(pred_addr), .pred_result_o(pred_result),
    .pred_prediction_i(pred_prediction)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Predictor model: counters start strongly not-taken; prediction registered every edge.
  logic [1:0] ctr [2] = '{2'b00, 2'b00};
  always @(posedge clk) begin
    pred_prediction <= ctr[pred_addr][1];
    if (pred_cs) begin
      if (pred_result && ctr[pred_addr] != 2'b11)       ctr[pred_addr] <= ctr[pred_addr] + 2'b01;
      else if (!pred_result && ctr[pred_addr] != 2'b00) ctr[pred_addr] <= ctr[pred_addr] - 2'b01;
    end
  end

  typedef struct packed { logic a; logic r; } upd_t;
  upd_t upd_q [$];
  logic lk_q  [$];
  upd_t head;
  logic exp_taken;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (lk_q.size() > 0) begin
        exp_taken = lk_q.pop_front();
        check("sb_resp_valid", lk_resp_valid, 1);
        check("sb_resp_taken", lk_resp_taken, exp_taken);
      end else begin
        check("sb_resp_idle", lk_resp_valid, 0);
      end
      if (rst) begin
        check("sb_rst_cs", pred_cs, 0);
        upd_q.delete();
      end else begin
        if (pred_cs) begin
          check("sb_cs_pending", upd_q.size() != 0, 1);
          if (upd_q.size() != 0) begin
            head = upd_q.pop_front();
            check("sb_upd_addr", pred_addr, head.a);
            check("sb_upd_result", pred_result, head.r);
          end
        end
        if (up_valid && up_ready) upd_q.push_back('{a: up_addr, r: up_result});
        if (lk_valid && lk_ready) lk_q.push_back(ctr[lk_addr][1]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic lv, la, uv, ua, ur);
    cyc();
    lk_valid = lv; lk_addr = la; up_valid = uv; up_addr = ua; up_result = ur;
    #1;
  endtask

  task automatic drain(input logic lv, input string name);
    int n = 0;
    while (up_count != 0 && n < 40) begin
      step(lv, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check({name, "_drained"}, up_count, 0);
    check({name, "_sb_empty"}, upd_q.size(), 0);
  endtask

  typedef struct {
    logic lv, la, uv, ua, ur;
    logic e_rdy, e_cs, e_addr, e_res;
    logic [2:0] e_cnt;
    logic e_rv, e_rt;
  } vec_t;
  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1);
  end

  initial begin
    // Training (rows 0-4), then starvation with lk_valid held (rows 5-11).
    vecs[0]  = '{0,0,1,1,1, 0,0,0,0, 3'd0, 0,0};
    vecs[1]  = '{0,0,1,1,1, 0,1,1,1, 3'd1, 0,0};
    vecs[2]  = '{0,0,0,0,0, 0,1,1,1, 3'd1, 0,0};
    vecs[3]  = '{1,1,0,0,0, 1,0,1,0, 3'd0, 0,0};
    vecs[4]  = '{1,0,0,0,0, 1,0,0,0, 3'd0, 1,1};
    vecs[5]  = '{1,0,1,0,1, 1,0,0,0, 3'd0, 1,0};
    vecs[6]  = '{1,0,0,0,0, 1,0,0,0, 3'd1, 1,0};
    vecs[7]  = '{1,0,0,0,0, 1,0,0,0, 3'd1, 1,0};
    vecs[8]  = '{1,0,0,0,0, 1,0,0,0, 3'd1, 1,0};
    vecs[9]  = '{1,0,0,0,0, 0,1,0,1, 3'd1, 1,0};
    vecs[10] = '{1,0,0,0,0, 1,0,0,0, 3'd0, 0,0};
    vecs[11] = '{0,0,0,0,0, 0,0,0,0, 3'd0, 1,0};

    rst = 1'b1; lk_valid = 1'b1; lk_addr = 1'b1;
    up_valid = 1'b0; up_addr = 1'b0; up_result = 1'b0;
    cyc();
    cyc();
    #1;
    check("rst_lk_ready", lk_ready, 0);
    check("rst_up_ready", up_ready, 0);
    check("rst_pred_cs", pred_cs, 0);
    check("rst_pred_addr", pred_addr, 0);
    check("rst_up_count", up_count, 0);
    check("rst_resp_valid", lk_resp_valid, 0);

    cyc();
    rst = 1'b0; mon_en = 1'b1;
    #1;
    check("lk1_ready", lk_ready, 1);
    check("lk1_pred_addr", pred_addr, 1);
    check("lk1_pred_cs", pred_cs, 0);
    step(0, 0, 0, 0, 0);
    check("lk1_resp_valid", lk_resp_valid, 1);
    check("lk1_resp_taken", lk_resp_taken, 0);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].lv, vecs[i].la, vecs[i].uv, vecs[i].ua, vecs[i].ur);
      check($sformatf("v%0d_lk_ready", i), lk_ready, vecs[i].e_rdy);
      check($sformatf("v%0d_pred_cs", i), pred_cs, vecs[i].e_cs);
      check($sformatf("v%0d_pred_addr", i), pred_addr, vecs[i].e_addr);
      check($sformatf("v%0d_pred_result", i), pred_result, vecs[i].e_res);
      check($sformatf("v%0d_up_count", i), up_count, vecs[i].e_cnt);
      check($sformatf("v%0d_resp_valid", i), lk_resp_valid, vecs[i].e_rv);
      check($sformatf("v%0d_resp_taken", i), lk_resp_taken, vecs[i].e_rt);
    end

    // FIFO fills under continuous lookups; the fifth update is offered while full.
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 0, 1);
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1);
    check("full_up_count", up_count, 4);
    check("full_up_ready", up_ready, 0);
    check("full_lk_ready", lk_ready, 0);
    check("full_pred_cs", pred_cs, 1);
    check("full_head_addr", pred_addr, 1);
    check("full_head_result", pred_result, 0);
    drain(1'b1, "full");

    // Push and pop in the same cycle at occupancy 2.
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    check("pp_count_before", up_count, 2);
    check("pp_pred_cs", pred_cs, 1);
    step(0, 0, 0, 0, 0);
    check("pp_count_after", up_count, 2);
    drain(1'b0, "pp");

    // Ten back-to-back updates walk the pointers around the FIFO more than twice.
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    drain(1'b0, "wrap");

    // Reset with three pending updates and a lookup response due.
    step(1, 1, 1, 0, 1);
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 0, 0);
    check("mid_count_pre", up_count, 2);
    cyc();
    rst = 1'b1; lk_valid = 1'b1; up_valid = 1'b0;
    #1;
    check("mid_rst_lk_ready", lk_ready, 0);
    check("mid_rst_pred_cs", pred_cs, 0);
    check("mid_rst_up_ready", up_ready, 0);
    cyc();
    rst = 1'b0; lk_valid = 1'b0;
    #1;
    check("mid_up_count", up_count, 0);
    check("mid_resp_valid", lk_resp_valid, 0);
    begin
      int n_cs = 0;
      for (int i = 0; i < 6; i++) begin
        if (pred_cs) n_cs++;
        step(0, 0, 0, 0, 0);
      end
      check("mid_no_cs_after", n_cs, 0);
    end

    step(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
